// File: rtl/detect_stream_ctrl_if.sv
// Word stream handshake between a word source and the detector sequencer.
// Latency: none, wires only.
// Backpressure: a transfer happens on any cycle with word_valid and word_ready both high.
// Ports: word_valid/word_data driven by the source (master), word_ready by the sequencer (slave).
interface detect_stream_ctrl_if #(
    parameter int WORD_W = 8
);
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (output word_valid, output word_data, input word_ready);
    modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/detect_stream_ctrl.sv
// Serialises a frame of words MSB-first into a bit-pattern detector and counts its match pulses.
// Latency: one bit per cycle; the first bit reaches det_din_bit two cycles after the first word is accepted.
// Backpressure: word_ready only when a new word is needed; a stalled source resets the detector and sets underrun.
// Ports: clk/reset; start+num_words begin a frame; word_if carries the word stream;
//        det_din_bit/det_reset/det_detect_out talk to the detector; match_count/busy/done/underrun report status.
module detect_stream_ctrl #(
    parameter int WORD_W  = 8,
    parameter int CNT_W   = 16,
    parameter int DET_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_words,
    detect_stream_ctrl_if.slave   word_if,
    output logic                  det_din_bit,
    output logic                  det_reset,
    input  logic                  det_detect_out,
    output logic [CNT_W-1:0]      match_count,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam int DR_W = $clog2(DET_LAT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_SHIFT,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;      // bits of the held word still to present
    logic [CNT_W-1:0]   words_left_q, words_left_d; // words not yet accepted in this frame
    logic               din_q, din_d;
    logic               det_rst_q, det_rst_d;
    logic [DET_LAT:0]   tag_q, tag_d;              // 1 marks a cycle carrying a real data bit
    logic [CNT_W-1:0]   match_q, match_d;
    logic               underrun_q, underrun_d;
    logic [DR_W-1:0]    drain_q, drain_d;
    logic               ready_int;
    logic               xfer;

    always_comb begin
        ready_int = 1'b0;
        case (state_q)
            S_FLUSH, S_GAP: ready_int = (words_left_q != '0);
            // Ready on the last bit so the next word loads with no bubble.
            S_SHIFT:        ready_int = (bit_cnt_q == BC_W'(1)) && (words_left_q != '0);
            default:        ready_int = 1'b0;
        endcase
    end

    assign xfer = word_if.word_valid && ready_int;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        words_left_d = words_left_q;
        din_d        = 1'b0;
        det_rst_d    = 1'b1;
        tag_d        = tag_q << 1;
        tag_d[0]     = 1'b0;
        match_d      = match_q;
        underrun_d   = underrun_q;
        drain_d      = drain_q;

        // A detector pulse only counts when the bit that caused it was real data.
        if (tag_q[DET_LAT] && det_detect_out && (match_q != '1)) begin
            match_d = match_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    match_d      = '0;
                    underrun_d   = 1'b0;
                    words_left_d = num_words;
                    state_d      = (num_words == '0) ? S_DONE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (xfer) begin
                    shreg_d      = word_if.word_data;
                    bit_cnt_d    = BC_W'(WORD_W);
                    words_left_d = words_left_q - 1'b1;
                    state_d      = S_SHIFT;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_SHIFT: begin
                det_rst_d = 1'b0;
                din_d     = shreg_q[WORD_W-1];
                tag_d[0]  = 1'b1;
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q - 1'b1;
                if (bit_cnt_q == BC_W'(1)) begin
                    if (xfer) begin
                        shreg_d      = word_if.word_data;
                        bit_cnt_d    = BC_W'(WORD_W);
                        words_left_d = words_left_q - 1'b1;
                    end else if (words_left_q != '0) begin
                        state_d = S_GAP;
                    end else begin
                        drain_d = DR_W'(DET_LAT);
                        state_d = S_DRAIN;
                    end
                end
            end
            S_GAP: begin
                // Detector history is discarded while the source is stalled.
                underrun_d = 1'b1;
                if (xfer) begin
                    shreg_d      = word_if.word_data;
                    bit_cnt_d    = BC_W'(WORD_W);
                    words_left_d = words_left_q - 1'b1;
                    state_d      = S_SHIFT;
                end
            end
            S_DRAIN: begin
                // Hold the detector out of reset until the last bit's pulse has been seen.
                det_rst_d = 1'b0;
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            words_left_q <= '0;
            din_q        <= 1'b0;
            det_rst_q    <= 1'b1;
            tag_q        <= '0;
            match_q      <= '0;
            underrun_q   <= 1'b0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            words_left_q <= words_left_d;
            din_q        <= din_d;
            det_rst_q    <= det_rst_d;
            tag_q        <= tag_d;
            match_q      <= match_d;
            underrun_q   <= underrun_d;
            drain_q      <= drain_d;
        end
    end

    assign word_if.word_ready = ready_int;
    assign det_din_bit        = din_q;
    assign det_reset          = reset | det_rst_q;
    assign match_count        = match_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign underrun           = underrun_q;
endmodule

// File: tb/tb_detect_stream_ctrl.sv
// Bench for detect_stream_ctrl driving a behavioural overlapping-1011 detector.
// Latency: frame results compared at each done pulse against a word-level model.
// Backpressure: the source inserts a chosen number of ready-but-not-valid cycles before each word.
module tb_detect_stream_ctrl;
    localparam int WORD_W  = 8;
    localparam int CNT_W   = 16;
    localparam int DET_LAT = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_words;
    logic             det_din_bit;
    logic             det_reset;
    logic             det_detect_out;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;
    logic             underrun;

    always #5 clk = ~clk;

    detect_stream_ctrl_if #(.WORD_W(WORD_W)) wif ();

    detect_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .DET_LAT(DET_LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_words      (num_words),
        .word_if        (wif.slave),
        .det_din_bit    (det_din_bit),
        .det_reset      (det_reset),
        .det_detect_out (det_detect_out),
        .match_count    (match_count),
        .busy           (busy),
        .done           (done),
        .underrun       (underrun)
    );

    // Behavioural detector: registered pulse one cycle after the bit completing 1011.
    logic [2:0] dh;
    logic       det_q;
    always @(posedge clk) begin
        if (det_reset) begin
            dh    <= 3'b000;
            det_q <= 1'b0;
        end else begin
            dh    <= {dh[1:0], det_din_bit};
            det_q <= ({dh, det_din_bit} == 4'b1011);
        end
    end
    assign det_detect_out = det_q;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame description and word-level model.
    logic [WORD_W-1:0] fw [4];
    int                fd [4];
    int                fn;
    int exp_count, exp_under, exp_gap, exp_words;

    function automatic int model_count();
        int         c   = 0;
        int         len = 0;
        logic [3:0] h   = 4'b0000;
        for (int i = 0; i < fn; i++) begin
            if (fd[i] > 0) begin
                h   = 4'b0000;
                len = 0;
            end
            for (int b = WORD_W - 1; b >= 0; b--) begin
                h = {h[2:0], fw[i][b]};
                len++;
                if (len >= 4 && h == 4'b1011) c++;
            end
        end
        if (c > (1 << CNT_W) - 1) c = (1 << CNT_W) - 1;
        return c;
    endfunction

    function automatic int model_under();
        int u = 0;
        for (int i = 0; i < fn; i++) if (fd[i] > 0) u = 1;
        return u;
    endfunction

    function automatic int model_gap();
        int g = 0;
        for (int i = 1; i < fn; i++) if (fd[i] > g) g = fd[i];
        return g;
    endfunction

    // Cycle monitor.
    bit mon_en = 0, prev_busy = 0, prev_done = 0, seen_low = 0;
    int run = 0, maxrun = 0, xfers = 0, dones = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy && !prev_busy) begin
                xfers = 0; seen_low = 0; run = 0; maxrun = 0;
            end
            if (busy) begin
                if (wif.word_valid && wif.word_ready) xfers++;
                if (!det_reset) begin
                    seen_low = 1; run = 0;
                end else if (seen_low) begin
                    run++;
                    if (run > maxrun) maxrun = run;
                end
            end else begin
                chk("idle_det_reset", det_reset, 1);
                chk("idle_word_ready", wif.word_ready, 0);
                chk("idle_done", done, 0);
            end
            if (prev_done) chk("busy_after_done", busy, 0);
            if (done) begin
                dones++;
                chk("done_busy", busy, 1);
                chk("done_match_count", match_count, exp_count);
                chk("done_underrun", underrun, exp_under);
                chk("done_gap_reset_run", maxrun, exp_gap);
                chk("done_words_taken", xfers, exp_words);
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n);
        int d0, idle, guard;
        bit sent;
        fn        = n;
        exp_count = model_count();
        exp_under = model_under();
        exp_gap   = model_gap();
        exp_words = n;
        d0        = dones;
        start     = 1'b1;
        num_words = CNT_W'(n);
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            idle = 0; guard = 0; sent = 0;
            while (!sent && guard < 100) begin
                if (wif.word_ready && idle >= fd[i]) begin
                    wif.word_valid = 1'b1;
                    wif.word_data  = fw[i];
                end else begin
                    wif.word_valid = 1'b0;
                end
                @(negedge clk);
                if (wif.word_valid && wif.word_ready) sent = 1;
                else if (wif.word_ready) idle++;
                tick();
                guard++;
            end
            wif.word_valid = 1'b0;
            if (!sent) chk("word_accept_timeout", 0, 1);
        end
        guard = 0;
        while (dones == d0 && guard < 200) begin
            tick();
            guard++;
        end
        tick();
        chk("done_pulses_per_frame", dones - d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        num_words      = '0;
        wif.word_valid = 1'b0;
        wif.word_data  = '0;
        for (int i = 0; i < 4; i++) begin fw[i] = '0; fd[i] = 0; end

        // 1: reset held three cycles.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_det_reset", det_reset, 1);
            chk("rst_busy", busy, 0);
            chk("rst_word_ready", wif.word_ready, 0);
            chk("rst_match_count", match_count, 0);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1;

        // Pin the model with hand-computed values.
        fn = 1; fw[0] = 8'b1011_0110; fd[0] = 0;
        chk("model_single_word", model_count(), 2);
        fn = 2; fw[0] = 8'h05; fw[1] = 8'h80; fd[0] = 0; fd[1] = 0;
        chk("model_cross_word", model_count(), 1);
        fd[1] = 3;
        chk("model_cross_word_gapped", model_count(), 0);
        chk("model_gap_len", model_gap(), 3);

        // 2: single word 1011_0110.
        fw[0] = 8'b1011_0110; fd[0] = 0;
        run_frame(1);
        chk("t2_match_count", match_count, 2);
        chk("t2_underrun", underrun, 0);

        // 4: two words with a three-cycle stall between them.
        fw[0] = 8'h05; fw[1] = 8'h80; fd[0] = 0; fd[1] = 3;
        run_frame(2);
        chk("t4_match_count", match_count, 0);
        chk("t4_underrun", underrun, 1);

        // 5: empty frame.
        fn = 0; exp_count = 0; exp_under = 0; exp_gap = 0; exp_words = 0;
        start     = 1'b1;
        num_words = '0;
        @(negedge clk);
        chk("t5_done_not_early", done, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("t5_done", done, 1);
        chk("t5_word_ready", wif.word_ready, 0);
        chk("t5_underrun_cleared", underrun, 0);
        tick();
        @(negedge clk);
        chk("t5_done_once", done, 0);
        chk("t5_match_count", match_count, 0);
        tick();

        // 3: two words back to back.
        fw[0] = 8'h0B; fw[1] = 8'hB0; fd[0] = 0; fd[1] = 0;
        run_frame(2);
        chk("t3_match_count", match_count, 2);
        chk("t3_underrun", underrun, 0);

        // 6: reset partway through the second word of a four-word frame.
        for (int i = 0; i < 4; i++) begin fw[i] = 8'hB6; fd[i] = 0; end
        fn = 4; exp_count = model_count(); exp_under = 0; exp_gap = 0; exp_words = 4;
        start          = 1'b1;
        num_words      = 16'd4;
        wif.word_valid = 1'b1;
        wif.word_data  = 8'hB6;
        tick();
        start = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        chk("t6_count_before_reset", match_count, 2);
        chk("t6_busy_before_reset", busy, 1);
        tick();
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        wif.word_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy_after_reset", busy, 0);
        chk("t6_count_after_reset", match_count, 0);
        chk("t6_ready_after_reset", wif.word_ready, 0);
        chk("t6_det_reset_after_reset", det_reset, 1);
        chk("t6_underrun_after_reset", underrun, 0);
        tick();

        // Fresh frame with a start pulse while busy that must be ignored.
        fw[0] = 8'hB6; fd[0] = 0;
        fork
            run_frame(1);
            begin
                repeat (5) tick();
                start     = 1'b1;
                num_words = 16'd3;
                tick();
                start = 1'b0;
            end
        join
        chk("t6_fresh_match_count", match_count, 2);
        repeat (4) begin
            @(negedge clk);
            chk("t6_stays_idle", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
